iob_cache_axi_write_channel: RTL and testbench

IOB_CACHE_AXI_WRITE_CHANNEL -- requirements
Module: iob_cache_axi_write_channel

---
 rtl/iob_cache_axi_write_channel.sv | 167 ++++++++++++++++
 tb/tb_iob_cache_axi_write_channel.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_axi_write_channel.sv
// AXI4 write master for the cache: single-word write-through or full-line write-back
// transactions, replayed from registered data whenever the slave returns an error response.
module iob_cache_axi_write_channel #(
  parameter int FE_ADDR_W     = 24,
  parameter int FE_DATA_W     = 32,
  parameter int BE_ADDR_W     = 24,
  parameter int BE_DATA_W     = 32,
  parameter int WORD_OFFSET_W = 3,
  parameter int WRITE_POL     = 0,
  parameter int AXI_ID_W      = 1,
  parameter int AXI_ID        = 0,
  parameter int AXI_LEN_W     = 8,
  localparam int FE_NBYTES_W  = $clog2(FE_DATA_W / 8),
  localparam int BE_NBYTES_W  = $clog2(BE_DATA_W / 8),
  localparam int LINE2BE_W    = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int ADDR_W       = FE_ADDR_W - FE_NBYTES_W - WRITE_POL * WORD_OFFSET_W,
  localparam int WDATA_W      = (WRITE_POL == 1) ? (FE_DATA_W << WORD_OFFSET_W) : FE_DATA_W
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   cke_i,
  input  logic                   write_valid_i,
  input  logic [ADDR_W-1:0]      write_addr_i,
  input  logic [WDATA_W-1:0]     write_wdata_i,
  input  logic [FE_DATA_W/8-1:0] write_wstrb_i,
  output logic                   write_ready_o,
  output logic [AXI_ID_W-1:0]    axi_awid_o,
  output logic [BE_ADDR_W-1:0]   axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]   axi_awlen_o,
  output logic [2:0]             axi_awsize_o,
  output logic [1:0]             axi_awburst_o,
  output logic [1:0]             axi_awlock_o,
  output logic [3:0]             axi_awcache_o,
  output logic [2:0]             axi_awprot_o,
  output logic [3:0]             axi_awqos_o,
  output logic                   axi_awvalid_o,
  input  logic                   axi_awready_i,
  output logic [BE_DATA_W-1:0]   axi_wdata_o,
  output logic [BE_DATA_W/8-1:0] axi_wstrb_o,
  output logic                   axi_wlast_o,
  output logic                   axi_wvalid_o,
  input  logic                   axi_wready_i,
  input  logic [AXI_ID_W-1:0]    axi_bid_i,
  input  logic [1:0]             axi_bresp_i,
  input  logic                   axi_bvalid_i,
  output logic                   axi_bready_o
);

  localparam int CNT_W     = (LINE2BE_W > 0) ? LINE2BE_W : 1;
  localparam int BEATS     = 1 << LINE2BE_W;
  localparam int BE_NBYTES = BE_DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WDATA_W-1:0]     wdata_q, wdata_d;
  logic [FE_DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                   last_beat;
  logic [FE_ADDR_W-1:0]   byte_addr;
  logic                   unused_ok;

  // Word or line address back to a byte address (low bits zero).
  assign byte_addr = FE_ADDR_W'(addr_q) << (FE_NBYTES_W + WRITE_POL * WORD_OFFSET_W);

  assign axi_awaddr_o  = BE_ADDR_W'(byte_addr);
  assign axi_awid_o    = AXI_ID_W'(AXI_ID);
  assign axi_awburst_o = 2'b01;
  assign axi_awlock_o  = 2'b00;
  assign axi_awcache_o = 4'b0011;
  assign axi_awprot_o  = 3'b000;
  assign axi_awqos_o   = 4'b0000;
  assign axi_wlast_o   = last_beat;

  assign unused_ok = ^{axi_bid_i, axi_bresp_i[0], wstrb_q, addr_q, cnt_q};

  if (WRITE_POL == 0) begin : g_wt
    assign last_beat    = 1'b1;
    assign axi_awlen_o  = '0;
    assign axi_awsize_o = 3'(FE_NBYTES_W);
    assign axi_wdata_o  = {(BE_DATA_W / FE_DATA_W){wdata_q}};
    if (BE_NBYTES_W > FE_NBYTES_W) begin : g_lane
      logic [BE_NBYTES_W-FE_NBYTES_W-1:0] lane;
      assign lane        = addr_q[BE_NBYTES_W-FE_NBYTES_W-1:0];
      assign axi_wstrb_o = BE_NBYTES'(wstrb_q) << (lane * (FE_DATA_W / 8));
    end else begin : g_nolane
      assign axi_wstrb_o = BE_NBYTES'(wstrb_q);
    end
  end else begin : g_wb
    assign last_beat    = (cnt_q == CNT_W'(BEATS - 1));
    assign axi_awlen_o  = AXI_LEN_W'(BEATS - 1);
    assign axi_awsize_o = 3'(BE_NBYTES_W);
    assign axi_wstrb_o  = '1;
    if (LINE2BE_W == 0) begin : g_one
      assign axi_wdata_o = wdata_q[BE_DATA_W-1:0];
    end else begin : g_multi
      logic [BE_DATA_W-1:0] beat [BEATS];
      for (genvar k = 0; k < BEATS; k++) begin : g_beat
        assign beat[k] = wdata_q[k*BE_DATA_W +: BE_DATA_W];
      end
      assign axi_wdata_o = beat[cnt_q];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    write_ready_o = 1'b0;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_bready_o  = 1'b0;
    case (state_q)
      IDLE: begin
        write_ready_o = 1'b1;
        if (write_valid_i) begin
          addr_d  = write_addr_i;
          wdata_d = write_wdata_i;
          wstrb_d = write_wstrb_i;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        axi_awvalid_o = 1'b1;
        if (axi_awready_i) state_d = DATA;
      end
      DATA: begin
        axi_wvalid_o = 1'b1;
        if (axi_wready_i) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESP: begin
        axi_bready_o = 1'b1;
        // Error responses replay the whole transaction from the held registers.
        if (axi_bvalid_i) state_d = axi_bresp_i[1] ? ADDR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_iob_cache_axi_write_channel.sv
// Directed bench: a write-through instance and a write-back instance share clock, reset and cke.
module tb_iob_cache_axi_write_channel;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic cke = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // write-through instance signals
  logic        t_valid = 0, t_ready;
  logic [21:0] t_addr = 0;
  logic [31:0] t_wdata = 0;
  logic [3:0]  t_wstrb = 0;
  logic [0:0]  t_awid;
  logic [23:0] t_awaddr;
  logic [7:0]  t_awlen;
  logic [2:0]  t_awsize, t_awprot;
  logic [1:0]  t_awburst, t_awlock;
  logic [3:0]  t_awcache, t_awqos;
  logic        t_awvalid, t_awready = 0;
  logic [31:0] t_wd;
  logic [3:0]  t_ws;
  logic        t_wlast, t_wvalid, t_wready = 0;
  logic [0:0]  t_bid = 0;
  logic [1:0]  t_bresp = 0;
  logic        t_bvalid = 0, t_bready;

  // write-back instance signals
  logic         b_valid = 0, b_ready;
  logic [18:0]  b_addr = 0;
  logic [255:0] b_line = 0;
  logic [3:0]   b_wstrb_in = 0;
  logic [0:0]   b_awid;
  logic [23:0]  b_awaddr;
  logic [7:0]   b_awlen;
  logic [2:0]   b_awsize, b_awprot;
  logic [1:0]   b_awburst, b_awlock;
  logic [3:0]   b_awcache, b_awqos;
  logic         b_awvalid, b_awready = 0;
  logic [31:0]  b_wd;
  logic [3:0]   b_ws;
  logic         b_wlast, b_wvalid, b_wready = 0;
  logic [0:0]   b_bid = 0;
  logic [1:0]   b_bresp = 0;
  logic         b_bvalid = 0, b_bready;

  iob_cache_axi_write_channel #(.WRITE_POL(0)) u_wt (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .write_valid_i(t_valid), .write_addr_i(t_addr), .write_wdata_i(t_wdata),
    .write_wstrb_i(t_wstrb), .write_ready_o(t_ready),
    .axi_awid_o(t_awid), .axi_awaddr_o(t_awaddr), .axi_awlen_o(t_awlen),
    .axi_awsize_o(t_awsize), .axi_awburst_o(t_awburst), .axi_awlock_o(t_awlock),
    .axi_awcache_o(t_awcache), .axi_awprot_o(t_awprot), .axi_awqos_o(t_awqos),
    .axi_awvalid_o(t_awvalid), .axi_awready_i(t_awready),
    .axi_wdata_o(t_wd), .axi_wstrb_o(t_ws), .axi_wlast_o(t_wlast),
    .axi_wvalid_o(t_wvalid), .axi_wready_i(t_wready),
    .axi_bid_i(t_bid), .axi_bresp_i(t_bresp), .axi_bvalid_i(t_bvalid),
    .axi_bready_o(t_bready)
  );

  iob_cache_axi_write_channel #(.WRITE_POL(1)) u_wb (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .write_valid_i(b_valid), .write_addr_i(b_addr), .write_wdata_i(b_line),
    .write_wstrb_i(b_wstrb_in), .write_ready_o(b_ready),
    .axi_awid_o(b_awid), .axi_awaddr_o(b_awaddr), .axi_awlen_o(b_awlen),
    .axi_awsize_o(b_awsize), .axi_awburst_o(b_awburst), .axi_awlock_o(b_awlock),
    .axi_awcache_o(b_awcache), .axi_awprot_o(b_awprot), .axi_awqos_o(b_awqos),
    .axi_awvalid_o(b_awvalid), .axi_awready_i(b_awready),
    .axi_wdata_o(b_wd), .axi_wstrb_o(b_ws), .axi_wlast_o(b_wlast),
    .axi_wvalid_o(b_wvalid), .axi_wready_i(b_wready),
    .axi_bid_i(b_bid), .axi_bresp_i(b_bresp), .axi_bvalid_i(b_bvalid),
    .axi_bready_o(b_bready)
  );

  // handshake counters
  int wt_aw_hs = 0, wt_w_hs = 0, wb_w_hs = 0;
  always @(posedge clk) begin
    if (arst_n && cke) begin
      if (t_awvalid && t_awready) wt_aw_hs <= wt_aw_hs + 1;
      if (t_wvalid && t_wready)   wt_w_hs  <= wt_w_hs + 1;
      if (b_wvalid && b_wready)   wb_w_hs  <= wb_w_hs + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wt_req(input logic [21:0] a, input logic [31:0] d, input logic [3:0] s);
    t_valid = 1; t_addr = a; t_wdata = d; t_wstrb = s;
    tick();
    t_valid = 0;
  endtask

  task automatic wb_req(input logic [18:0] a, input logic [31:0] base, input logic [31:0] step);
    b_valid = 1; b_addr = a;
    for (int i = 0; i < 8; i++) b_line[i*32 +: 32] = base + step * i;
    tick();
    b_valid = 0;
  endtask

  int aw0, w0, k;

  initial begin
    #1;
    chk("rst_t_ready", t_ready, 1);
    chk("rst_t_awvalid", t_awvalid, 0);
    chk("rst_t_wvalid", t_wvalid, 0);
    chk("rst_t_bready", t_bready, 0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_b_wvalid", b_wvalid, 0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1;

    // write-through single word
    t_awready = 1; t_wready = 1;
    wt_req(22'h000040, 32'hDEADBEEF, 4'hF);
    chk("t1_ready_busy", t_ready, 0);
    chk("t1_awvalid", t_awvalid, 1);
    chk("t1_awaddr", t_awaddr, 24'h000100);
    chk("t1_awlen", t_awlen, 0);
    chk("t1_awsize", t_awsize, 2);
    chk("t1_awburst", t_awburst, 1);
    chk("t1_awcache", t_awcache, 4'b0011);
    chk("t1_wvalid_pre", t_wvalid, 0);
    tick();
    chk("t1_wvalid", t_wvalid, 1);
    chk("t1_wdata", t_wd, 32'hDEADBEEF);
    chk("t1_wstrb", t_ws, 4'hF);
    chk("t1_wlast", t_wlast, 1);
    chk("t1_awvalid_off", t_awvalid, 0);
    tick();
    chk("t1_bready", t_bready, 1);
    chk("t1_wvalid_off", t_wvalid, 0);
    chk("t1_ready_resp", t_ready, 0);
    t_bvalid = 1; t_bresp = 2'b00;
    tick();
    t_bvalid = 0;
    chk("t1_ready_back", t_ready, 1);
    chk("t1_bready_off", t_bready, 0);

    // AW stall with stray bvalid that must be ignored
    t_awready = 0;
    wt_req(22'h000041, 32'h12345678, 4'h3);
    t_bvalid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_awvalid_hold", t_awvalid, 1);
      chk("t2_awaddr_hold", t_awaddr, 24'h000104);
      chk("t2_wvalid_low", t_wvalid, 0);
      tick();
    end
    t_bvalid = 0;
    chk("t2_still_addr", t_awvalid, 1);
    t_awready = 1;
    tick();
    chk("t2_wvalid", t_wvalid, 1);
    chk("t2_awvalid_off", t_awvalid, 0);
    chk("t2_wstrb", t_ws, 4'h3);
    chk("t2_wdata", t_wd, 32'h12345678);
    tick();
    t_bvalid = 1;
    tick();
    t_bvalid = 0;
    chk("t2_ready_back", t_ready, 1);

    // error response then OKAY: replay
    aw0 = wt_aw_hs; w0 = wt_w_hs;
    wt_req(22'h000010, 32'hCAFEF00D, 4'hC);
    chk("t3_awaddr_1", t_awaddr, 24'h000040);
    tick();
    chk("t3_wdata_1", t_wd, 32'hCAFEF00D);
    tick();
    chk("t3_bready_1", t_bready, 1);
    t_bvalid = 1; t_bresp = 2'b10;
    tick();
    t_bvalid = 0; t_bresp = 2'b00;
    chk("t3_retry_awvalid", t_awvalid, 1);
    chk("t3_retry_awaddr", t_awaddr, 24'h000040);
    chk("t3_retry_ready", t_ready, 0);
    tick();
    chk("t3_wdata_2", t_wd, 32'hCAFEF00D);
    chk("t3_wstrb_2", t_ws, 4'hC);
    tick();
    chk("t3_bready_2", t_bready, 1);
    t_bvalid = 1;
    tick();
    t_bvalid = 0;
    chk("t3_ready_back", t_ready, 1);
    chk("t3_aw_count", wt_aw_hs - aw0, 2);
    chk("t3_w_count", wt_w_hs - w0, 2);
    tick();
    chk("t3_idle_stays", t_awvalid, 0);

    // write-back burst with wready toggling
    b_awready = 1; b_wready = 0;
    wb_req(19'h00123, 32'h11111111, 32'h11111111);
    chk("t4_awvalid", b_awvalid, 1);
    chk("t4_awaddr", b_awaddr, 24'h002460);
    chk("t4_awlen", b_awlen, 7);
    chk("t4_awsize", b_awsize, 2);
    chk("t4_wvalid_pre", b_wvalid, 0);
    tick();
    w0 = wb_w_hs;
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      b_wready = c[0];
      chk("t4_wvalid", b_wvalid, 1);
      chk("t4_wdata", b_wd, 32'h11111111 * (k + 1));
      chk("t4_wstrb", b_ws, 4'hF);
      chk("t4_wlast", b_wlast, (k == 7));
      tick();
      if (b_wready) k++;
    end
    b_wready = 0;
    chk("t4_beats_done", k, 8);
    chk("t4_w_count", wb_w_hs - w0, 8);
    chk("t4_bready", b_bready, 1);
    chk("t4_wvalid_off", b_wvalid, 0);
    b_bvalid = 1;
    tick();
    b_bvalid = 0;
    chk("t4_ready_back", b_ready, 1);

    // clock-enable freeze mid-burst
    wb_req(19'h00456, 32'hA0000000, 32'h1);
    tick();
    b_wready = 1;
    tick();
    tick();
    chk("t5_beat2", b_wd, 32'hA0000002);
    w0 = wb_w_hs;
    cke = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_frz_wdata", b_wd, 32'hA0000002);
      chk("t5_frz_wvalid", b_wvalid, 1);
      chk("t5_frz_wlast", b_wlast, 0);
      chk("t5_frz_awvalid", b_awvalid, 0);
    end
    chk("t5_frz_count", wb_w_hs - w0, 0);
    cke = 1;
    for (int j = 2; j < 8; j++) begin
      chk("t5_wdata", b_wd, 32'hA0000000 + j);
      chk("t5_wlast", b_wlast, (j == 7));
      tick();
    end
    b_wready = 0;
    chk("t5_bready", b_bready, 1);
    b_bvalid = 1;
    tick();
    b_bvalid = 0;
    chk("t5_ready_back", b_ready, 1);

    // asynchronous reset during beat 3
    wb_req(19'h00010, 32'h55550000, 32'h1);
    tick();
    b_wready = 1;
    tick();
    tick();
    chk("t6_beat2", b_wd, 32'h55550002);
    b_wready = 0;
    #2 arst_n = 0;
    #1;
    chk("t6_rst_awvalid", b_awvalid, 0);
    chk("t6_rst_wvalid", b_wvalid, 0);
    chk("t6_rst_bready", b_bready, 0);
    chk("t6_rst_ready", b_ready, 1);
    chk("t6_rst_t_ready", t_ready, 1);
    @(posedge clk);
    #1 arst_n = 1;
    b_awready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_aw", b_awvalid, 0);
      chk("t6_idle_ready", b_ready, 1);
    end
    wb_req(19'h00020, 32'h77770000, 32'h1);
    chk("t6_new_awvalid", b_awvalid, 1);
    chk("t6_new_awaddr", b_awaddr, 24'h000400);
    tick();
    chk("t6_new_beat0", b_wd, 32'h77770000);
    b_wready = 1;
    repeat (8) tick();
    b_wready = 0;
    chk("t6_bready", b_bready, 1);
    b_bvalid = 1;
    tick();
    b_bvalid = 0;
    chk("t6_ready_back", b_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
